// File: rtl/multisymbol_serial_decoder_pkg.sv
// Shared types and helpers for the multisymbol serial decoder.
// Carry width derivation and the symbols-per-cycle divisibility check.
package multisymbol_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } msdec_state_t;

  function automatic int carrywidth(
    input int symbolbitwidth,
    input int logradix
  );
    return symbolbitwidth - logradix + 1;
  endfunction

  function automatic bit spc_divides(
    input int numsymbols,
    input int spc
  );
    return (spc > 0) && ((numsymbols % spc) == 0);
  endfunction

endpackage

// File: rtl/multisymbol_serial_decoder_if.sv
// Valid/ready bundle between the squaring datapath and the decoder.
// slave is the decoder side, master is the producer/consumer side.
interface multisymbol_serial_decoder_if #(
  parameter int NUMSYMBOLS = 32,
  parameter int SBW        = 35,
  parameter int OBW        = 1056,
  parameter int CW         = 3
);

  logic                           in_valid;
  logic                           in_ready;
  logic [NUMSYMBOLS-1:0][SBW-1:0] in_symbols;
  logic                           out_valid;
  logic                           out_ready;
  logic [OBW-1:0]                 out_data;
  logic [CW-1:0]                  out_aux;

  modport master (
    output in_valid,
    output in_symbols,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_aux
  );

  modport slave (
    input  in_valid,
    input  in_symbols,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_aux
  );

endinterface

// File: rtl/multisymbol_serial_decoder_carry_slice.sv
// Ripples a signed carry through SPC redundant symbols in one cycle.
// Each symbol plus carry yields one LOGRADIX-bit digit and a new carry.
module multisymbol_carry_slice
  import multisymbol_pkg::*;
#(
  parameter int SPC      = 4,
  parameter int LOGRADIX = 33,
  parameter int SBW      = LOGRADIX + 2,
  parameter int CW       = carrywidth(SBW, LOGRADIX)
) (
  input  logic [SPC-1:0][SBW-1:0]  sym_i,
  input  logic [CW-1:0]            carry_i,
  output logic [SPC*LOGRADIX-1:0]  digit_o,
  output logic [CW-1:0]            carry_o
);

  localparam int SW = SBW + 1;

  // sum = sext(sym) + sext(carry); digit is the low part, carry the rest
  always_comb begin : p_ripple
    logic [SW-1:0] sum;
    logic [CW-1:0] c;
    sum     = '0;
    c       = carry_i;
    digit_o = '0;
    for (int j = 0; j < SPC; j++) begin
      sum = {sym_i[j][SBW-1], sym_i[j]}
          + {{(SW-CW){c[CW-1]}}, c};
      digit_o[j*LOGRADIX +: LOGRADIX] = sum[LOGRADIX-1:0];
      c = sum[SW-1:LOGRADIX];
    end
    carry_o = c;
  end

endmodule

// File: rtl/multisymbol_serial_decoder.sv
// Converts redundant signed multisymbol vectors to plain binary,
// resolving SYMBOLS_PER_CYCLE symbols per clock, lowest first.
module multisymbol_serial_decoder
  import multisymbol_pkg::*;
#(
  parameter int NUMSYMBOLS        = 32,
  parameter int LOGRADIX          = 33,
  parameter int SYMBOLBITWIDTH    = LOGRADIX + 2,
  parameter int SYMBOLS_PER_CYCLE = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  multisymbol_serial_decoder_if.slave   bus,
  output logic                          busy
);

  localparam int SBW            = SYMBOLBITWIDTH;
  localparam int SPC            = SYMBOLS_PER_CYCLE;
  localparam int OUTPUTBITWIDTH = NUMSYMBOLS * LOGRADIX;
  localparam int CARRYWIDTH     = carrywidth(SBW, LOGRADIX);
  localparam int N              = NUMSYMBOLS / SPC;
  localparam int IW             = (N > 1) ? $clog2(N) : 1;
  localparam int SLW            = SPC * LOGRADIX;

  if (!spc_divides(NUMSYMBOLS, SPC)) begin : g_bad_spc
    $error("SYMBOLS_PER_CYCLE must divide NUMSYMBOLS");
  end

  msdec_state_t                   state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [CARRYWIDTH-1:0]          carry_q, carry_d;
  logic [NUMSYMBOLS-1:0][SBW-1:0] sym_q, sym_d;
  logic [OUTPUTBITWIDTH-1:0]      data_q, data_d;
  logic [CARRYWIDTH-1:0]          aux_q, aux_d;

  logic [SPC-1:0][SBW-1:0]        slice_sym;
  logic [SLW-1:0]                 slice_dig;
  logic [CARRYWIDTH-1:0]          slice_cout;

  assign slice_sym = sym_q[int'(idx_q)*SPC +: SPC];

  multisymbol_carry_slice #(
    .SPC      (SPC),
    .LOGRADIX (LOGRADIX),
    .SBW      (SBW),
    .CW       (CARRYWIDTH)
  ) u_slice (
    .sym_i   (slice_sym),
    .carry_i (carry_q),
    .digit_o (slice_dig),
    .carry_o (slice_cout)
  );

  // Next-state: accept in IDLE, ripple one slice per RUN cycle, hold in DONE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sym_d   = sym_q;
    data_d  = data_q;
    aux_d   = aux_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sym_d   = bus.in_symbols;
          carry_d = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        data_d[int'(idx_q)*SLW +: SLW] = slice_dig;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(N - 1)) begin
          aux_d   = slice_cout;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= '0;
      data_q  <= '0;
      aux_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      data_q  <= data_d;
      aux_q   <= aux_d;
    end
  end

  // Symbol capture needs no reset; it is only read after an accept
  always_ff @(posedge clk) begin
    sym_q <= sym_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_aux   = aux_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_multisymbol_serial_decoder.sv
// Scoreboard bench for multisymbol_serial_decoder: directed vectors,
// backpressure, mid-job reset and randomised conversion jobs.
module tb_multisymbol_serial_decoder;

  localparam int NS  = 32;
  localparam int LR  = 33;
  localparam int SBW = LR + 2;
  localparam int SPC = 4;
  localparam int OBW = NS * LR;
  localparam int CW  = SBW - LR + 1;
  localparam int EW  = OBW + CW;

  typedef logic [NS-1:0][SBW-1:0] vec_t;
  typedef struct packed {
    logic [OBW-1:0] d;
    logic [CW-1:0]  a;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;
  exp_t sbq[$];

  multisymbol_serial_decoder_if #(
    .NUMSYMBOLS (NS),
    .SBW        (SBW),
    .OBW        (OBW),
    .CW         (CW)
  ) bus ();

  multisymbol_serial_decoder #(
    .NUMSYMBOLS        (NS),
    .LOGRADIX          (LR),
    .SYMBOLBITWIDTH    (SBW),
    .SYMBOLS_PER_CYCLE (SPC)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [OBW-1:0] act,
                          input logic [OBW-1:0] exp);
    int k;
    checks++;
    if (act !== exp) begin
      errors++;
      k = 0;
      while (k < NS - 1 && act[k*LR +: LR] === exp[k*LR +: LR]) k++;
      $display("FAIL %s digit %0d got %h want %h", nm, k,
               act[k*LR +: LR], exp[k*LR +: LR]);
    end
  endtask

  // Exact big-integer value of a symbol vector, wide enough for the carry
  function automatic exp_t model(input vec_t s);
    logic signed [EW-1:0] acc;
    logic signed [EW-1:0] t;
    exp_t e;
    acc = '0;
    for (int i = 0; i < NS; i++) begin
      t   = {{(EW-SBW){s[i][SBW-1]}}, s[i]};
      acc = acc + (t <<< (i * LR));
    end
    e.d = acc[OBW-1:0];
    e.a = acc[EW-1:OBW];
    return e;
  endfunction

  // Monitor: compare every DONE cycle against the head, pop on handshake
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid got 1 want 0");
      end else begin
        chk_data("out_data", bus.out_data, sbq[0].d);
        chk("out_aux", 64'(bus.out_aux), 64'(sbq[0].a));
        if (bus.out_ready) void'(sbq.pop_front());
      end
    end
  end

  // Consumer backpressure: 0 always ready, 1 random, 2 held off
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  task automatic send(input vec_t s, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready got 0 want 1");
      return;
    end
    bus.in_valid   = 1'b1;
    bus.in_symbols = s;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.in_symbols = '1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 64'(sbq.size()), 64'd0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t s;
    exp_t e;
    logic [OBW-1:0] d;
    int n;

    bus.in_valid   = 1'b0;
    bus.in_symbols = '0;
    bus.out_ready  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk_data("rst_out_data", bus.out_data, '0);
    chk("rst_out_aux", 64'(bus.out_aux), 64'd0);
    rst = 1'b0;

    // All zero: latency of N=8 cycles from accept to out_valid
    s = '0; e.d = '0; e.a = '0;
    send(s, e);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.out_valid && n < 20);
    chk("latency_cycles", 64'(n), 64'd8);
    drain();

    // sym[0] = -1 -> all ones with a -1 carry above
    s = '0; s[0] = '1;
    e.d = '1; e.a = 3'b111;
    send(s, e);
    drain();

    // Every symbol one above digit max
    for (int i = 0; i < NS; i++) s[i] = SBW'(1) << LR;
    e.d = '0;
    for (int i = 0; i < NS - 1; i++) e.d[(i + 1) * LR] = 1'b1;
    e.a = 3'd1;
    send(s, e);
    drain();

    // Largest positive top symbol: digit all ones, carry +1
    s = '0; s[NS-1] = {1'b0, {(SBW-1){1'b1}}};
    e.d = '0; e.d[(NS-1)*LR +: LR] = '1;
    e.a = 3'd1;
    send(s, e);
    drain();

    // Backpressure: result held, input blocked, in_valid pulses ignored
    rdy_mode = 2;
    s = '0; s[5] = SBW'(12345); s[6] = '1;
    e.d = '0; e.d[5*LR +: LR] = 33'd12345;
    e.d[6*LR +: LR] = '1; e.d[OBW-1:7*LR] = '1;
    e.a = 3'b111;
    send(s, e);
    n = 0;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid   = 1'(i % 2);
      bus.in_symbols = '1;
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("release_out_valid", 64'(bus.out_valid), 64'd0);
    chk("release_queue", 64'(sbq.size()), 64'd0);

    // Reset in RUN cycle 3 discards the job
    s = '0; s[0] = SBW'(7);
    e.d = '0; e.d[0 +: LR] = 33'd7; e.a = '0;
    send(s, e);
    repeat (3) @(posedge clk);
    @(negedge clk);
    void'(sbq.pop_back());
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (15) @(negedge clk);

    // Next job after reset still decodes
    for (int i = 0; i < NS; i++) s[i] = SBW'(1) << LR;
    e.d = '0;
    for (int i = 0; i < NS - 1; i++) e.d[(i + 1) * LR] = 1'b1;
    e.a = 3'd1;
    send(s, e);
    drain();

    // Negated digit vectors of random data: result is 0 - data
    rdy_mode = 1;
    for (int j = 0; j < 1000; j++) begin
      for (int w = 0; w < OBW / 32; w++) d[w*32 +: 32] = $urandom;
      if (j % 97 == 0) d = '0;
      for (int i = 0; i < NS; i++)
        s[i] = SBW'(0) - {2'b00, d[i*LR +: LR]};
      e.d = OBW'(0) - d;
      e.a = (d == '0) ? 3'd0 : 3'b111;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(s, e);
    end

    // Fully random redundant symbols against the exact sum
    for (int j = 0; j < 50; j++) begin
      for (int i = 0; i < NS; i++) s[i] = SBW'({$urandom, $urandom});
      e = model(s);
      send(s, e);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
